// File: rtl/posit_decoder_if.sv
// Request/result bundle for posit_decoder: one posit word in, decoded fields out.
interface posit_decoder_if #(
  parameter int N         = 32,
  parameter int ES        = 3,
  parameter int K_BITS    = 6,
  parameter int FRAC_BITS = N - ES - 3
);
  logic                     start;
  logic [N-1:0]             posit_in;
  logic                     sign_out;
  logic signed [K_BITS-1:0] k_out;
  logic [ES-1:0]            exp_out;
  logic [FRAC_BITS-1:0]     frac_out;
  logic                     zero_out;
  logic                     NaR;
  logic                     busy;
  logic                     done;

  modport master (
    output start, posit_in,
    input  sign_out, k_out, exp_out, frac_out, zero_out, NaR, busy, done
  );

  modport slave (
    input  start, posit_in,
    output sign_out, k_out, exp_out, frac_out, zero_out, NaR, busy, done
  );
endinterface

// File: rtl/posit_decoder.sv
// Sequential posit field extractor: sign, regime k, exponent, fraction, zero/NaR.
// Build option POSIT_DEC_FAST_SCAN_EN replaces the bit-serial regime scan with a one-cycle run counter.
module posit_decoder #(
  parameter int N         = 32,
  parameter int ES        = 3,
  parameter int K_BITS    = 6,
  parameter int FRAC_BITS = N - ES - 3
) (
  input  logic            clk,
  input  logic            rst,
  posit_decoder_if.slave  bus
);
  localparam int RUN_W = $clog2(N) + 1;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(N - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SCAN, EXTRACT, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [N-1:0]     p;
  logic [N-2:0]     sr;
  logic             r0;
  logic [RUN_W-1:0] run;

  logic             is_zero;
  logic             is_nar;
  logic [N-2:0]     body;

  function automatic logic signed [K_BITS-1:0] calc_k(input logic r0_f,
                                                      input logic [RUN_W-1:0] run_f);
    int kv;
    kv = r0_f ? (int'(run_f) - 1) : -int'(run_f);
    return kv[K_BITS-1:0];
  endfunction

  assign is_zero = (p == '0);
  assign is_nar  = (p == {1'b1, {(N-1){1'b0}}});
  // Only the low N-1 bits of the magnitude are needed; they depend only on p[N-2:0].
  assign body    = p[N-1] ? (~p[N-2:0] + 1'b1) : p[N-2:0];
  assign bus.busy = (state != IDLE);

`ifdef POSIT_DEC_FAST_SCAN_EN
  logic [RUN_W-1:0] lead_cnt;
  logic             hit_term;
  logic [RUN_W-1:0] shamt;

  always_comb begin
    lead_cnt = '0;
    hit_term = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!hit_term) begin
        if (sr[i] == r0) lead_cnt = lead_cnt + 1'b1;
        else             hit_term = 1'b1;
      end
    end
  end

  assign shamt = lead_cnt + {{(RUN_W-1){1'b0}}, hit_term};
`else
  logic             scan_match;
  logic [RUN_W-1:0] run_inc;

  assign scan_match = (sr[N-2] == r0);
  assign run_inc    = run + 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = LOAD;
      LOAD:    state_nxt = (is_zero || is_nar) ? DONE : SCAN;
`ifdef POSIT_DEC_FAST_SCAN_EN
      SCAN:    state_nxt = EXTRACT;
`else
      SCAN:    if (!scan_match || (run_inc == RUN_MAX)) state_nxt = EXTRACT;
`endif
      EXTRACT: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bus.done     <= 1'b0;
      bus.sign_out <= 1'b0;
      bus.k_out    <= '0;
      bus.exp_out  <= '0;
      bus.frac_out <= '0;
      bus.zero_out <= 1'b0;
      bus.NaR      <= 1'b0;
    end else begin
      state    <= state_nxt;
      bus.done <= (state_nxt == DONE);
      case (state)
        IDLE: if (bus.start) p <= bus.posit_in;
        LOAD: begin
          if (is_zero || is_nar) begin
            bus.zero_out <= is_zero;
            bus.NaR      <= is_nar;
            bus.sign_out <= 1'b0;
            bus.k_out    <= '0;
            bus.exp_out  <= '0;
            bus.frac_out <= '0;
          end else begin
            bus.sign_out <= p[N-1];
            bus.zero_out <= 1'b0;
            bus.NaR      <= 1'b0;
            sr           <= body;
            r0           <= body[N-2];
            run          <= '0;
          end
        end
`ifdef POSIT_DEC_FAST_SCAN_EN
        SCAN: begin
          run <= lead_cnt;
          sr  <= sr << shamt;
        end
`else
        SCAN: begin
          if (scan_match) run <= run_inc;
          sr <= sr << 1;
        end
`endif
        EXTRACT: begin
          bus.k_out    <= calc_k(r0, run);
          bus.exp_out  <= sr[N-2 -: ES];
          bus.frac_out <= sr[N-2-ES -: FRAC_BITS];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_posit_decoder.sv
// Randomized and directed bench for posit_decoder against an arithmetic posit-decoding model.
module tb_posit_decoder;
  localparam int N = 32, ES = 3, K_BITS = 6, FRAC_BITS = N - ES - 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  posit_decoder_if #(.N(N), .ES(ES), .K_BITS(K_BITS), .FRAC_BITS(FRAC_BITS)) bus ();

  posit_decoder #(.N(N), .ES(ES), .K_BITS(K_BITS), .FRAC_BITS(FRAC_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        sign;
    int          k;
    logic [2:0]  e;
    logic [25:0] f;
    logic        z;
    logic        nar;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] x;
    exp_t        want;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;
  int last_lat = -1;
  exp_t exp_q[$];
  int   acc_q[$];
  int   done_cycs[$];

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  // Decode by value: two's-complement magnitude, count the regime run, then read ES and fraction bits.
  function automatic exp_t model(input logic [31:0] x);
    exp_t r;
    logic [31:0] mag;
    logic [30:0] bits;
    logic [63:0] t;
    logic        lead;
    int          m;
    r = '{default: 0};
    if (x == 32'h0) begin
      r.z = 1'b1; r.lat = 2; return r;
    end
    if (x == 32'h8000_0000) begin
      r.nar = 1'b1; r.lat = 2; return r;
    end
    r.sign = x[31];
    mag  = x[31] ? (32'h0 - x) : x;
    bits = mag[30:0];
    lead = bits[30];
    m = 0;
    while (m < 31 && bits[30 - m] == lead) m++;
    t = {bits, 33'h0};
    t = t << (m + ((m < 31) ? 1 : 0));
    r.e = t[63:61];
    r.f = t[60:35];
    r.k = lead ? (m - 1) : -m;
`ifdef POSIT_DEC_FAST_SCAN_EN
    r.lat = 4;
`else
    r.lat = ((m < 31) ? (m + 1) : 31) + 3;
`endif
    return r;
  endfunction

  // Compare process: samples 1 time unit after every rising edge.
  always @(posedge clk) begin
    logic [31:0] edge_in;
    logic        edge_rst;
    logic        prev_busy;
    logic        prev_done;
    exp_t        e;
    int          acc;
    edge_in  = bus.posit_in;
    edge_rst = rst;
    cyc++;
    #1;
    if (edge_rst) begin
      exp_q.delete();
      acc_q.delete();
    end else begin
      if (bus.busy && !prev_busy) begin
        exp_q.push_back(model(edge_in));
        acc_q.push_back(cyc);
      end
      if (bus.done) begin
        done_cnt++;
        done_cycs.push_back(cyc);
        chk("done_width", prev_done, 0);
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got done=1 want no pending decode (t=%0t)", $time);
        end else begin
          e   = exp_q.pop_front();
          acc = acc_q.pop_front();
          last_lat = cyc - acc + 1;
          chk("sign", bus.sign_out, e.sign);
          chk("k",    bus.k_out,    e.k);
          chk("exp",  bus.exp_out,  e.e);
          chk("frac", bus.frac_out, e.f);
          chk("zero", bus.zero_out, e.z);
          chk("nar",  bus.NaR,      e.nar);
          chk("latency", last_lat,  e.lat);
        end
      end
    end
    prev_busy = bus.busy;
    prev_done = bus.done;
  end

  task automatic wait_done(input int n0, input int limit, input string name);
    int w;
    w = 0;
    while (done_cnt == n0 && w < limit) begin
      @(negedge clk);
      w++;
    end
    if (done_cnt == n0) begin
      total++; bad++;
      $display("FAIL %s_timeout: got no done in %0d cycles want done", name, limit);
    end
  endtask

  task automatic run_op(input logic [31:0] x);
    int n0;
    n0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.posit_in = x;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(n0, 60, "op");
  endtask

  vec_t tbl[7];
  int   lit_lat[7];

  initial begin
    exp_t m;
    int   n0;
    int   w;
    int   per;
    logic [31:0] x;

    bus.start = 1'b0;
    bus.posit_in = '0;
    tbl[0] = '{32'h4000_0000, '{1'b0,   0, 3'd0, 26'h0,       1'b0, 1'b0, 0}};
    tbl[1] = '{32'h4A00_0000, '{1'b0,   0, 3'd2, 26'h200_0000, 1'b0, 1'b0, 0}};
    tbl[2] = '{32'hC000_0000, '{1'b1,   0, 3'd0, 26'h0,       1'b0, 1'b0, 0}};
    tbl[3] = '{32'h0000_0000, '{1'b0,   0, 3'd0, 26'h0,       1'b1, 1'b0, 0}};
    tbl[4] = '{32'h8000_0000, '{1'b0,   0, 3'd0, 26'h0,       1'b0, 1'b1, 0}};
    tbl[5] = '{32'h7FFF_FFFF, '{1'b0,  30, 3'd0, 26'h0,       1'b0, 1'b0, 0}};
    tbl[6] = '{32'h0000_0001, '{1'b0, -30, 3'd0, 26'h0,       1'b0, 1'b0, 0}};
`ifdef POSIT_DEC_FAST_SCAN_EN
    lit_lat = '{4, 4, 4, 2, 2, 4, 4};
`else
    lit_lat = '{5, 5, 5, 2, 2, 34, 34};
`endif

    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy,     0);
    chk("rst_done", bus.done,     0);
    chk("rst_sign", bus.sign_out, 0);
    chk("rst_k",    bus.k_out,    0);
    chk("rst_exp",  bus.exp_out,  0);
    chk("rst_frac", bus.frac_out, 0);
    chk("rst_zero", bus.zero_out, 0);
    chk("rst_nar",  bus.NaR,      0);
    rst = 1'b0;

    // Directed vectors: pin both the model and the DUT to hand-derived values.
    for (int i = 0; i < 7; i++) begin
      m = model(tbl[i].x);
      chk("model_k",   m.k,   tbl[i].want.k);
      chk("model_exp", m.e,   tbl[i].want.e);
      chk("model_frac", m.f,  tbl[i].want.f);
      chk("model_lat", m.lat, lit_lat[i]);
      run_op(tbl[i].x);
      chk("lit_sign", bus.sign_out, tbl[i].want.sign);
      chk("lit_k",    bus.k_out,    tbl[i].want.k);
      chk("lit_exp",  bus.exp_out,  tbl[i].want.e);
      chk("lit_frac", bus.frac_out, tbl[i].want.f);
      chk("lit_zero", bus.zero_out, tbl[i].want.z);
      chk("lit_nar",  bus.NaR,      tbl[i].want.nar);
      chk("lit_lat",  last_lat,     lit_lat[i]);
    end

    // start pulsed while a decode is in flight must be ignored.
    n0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.posit_in = 32'h0000_0001;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.posit_in = 32'h4000_0000;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(n0, 60, "ignore_start");
    repeat (12) @(negedge clk);
    chk("ignore_start_dones", done_cnt - n0, 1);
    chk("ignore_start_idle", bus.busy, 0);

    // Reset in the middle of a decode.
    n0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.posit_in = 32'h0000_0003;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    run_op(32'h7FFF_FFFF);
    n0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.posit_in = 32'h0000_0001;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", bus.busy,     0);
    chk("midrst_done", bus.done,     0);
    chk("midrst_sign", bus.sign_out, 0);
    chk("midrst_k",    bus.k_out,    0);
    chk("midrst_exp",  bus.exp_out,  0);
    chk("midrst_zero", bus.zero_out, 0);
    chk("midrst_nar",  bus.NaR,      0);
    repeat (40) @(negedge clk);
    chk("midrst_no_done", done_cnt - n0, 0);
    run_op(32'hC000_0000);

    // start held high: decodes repeat every L+1 cycles.
    m = model(32'h4A00_0000);
    n0 = done_cnt;
    done_cycs.delete();
    @(negedge clk);
    bus.start = 1'b1; bus.posit_in = 32'h4A00_0000;
    w = 0;
    while (done_cnt < n0 + 3 && w < 200) begin
      @(negedge clk);
      w++;
    end
    bus.start = 1'b0;
    if (done_cycs.size() >= 3) begin
      per = m.lat + 1;
      chk("held_period1", done_cycs[1] - done_cycs[0], per);
      chk("held_period2", done_cycs[2] - done_cycs[1], per);
    end else begin
      total++; bad++;
      $display("FAIL held_start: got %0d done pulses want 3", done_cycs.size());
    end
    repeat (4) @(negedge clk);

    // Randomized operands with biased regime run lengths and specials.
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 9))
        0:       x = 32'h0;
        1:       x = 32'h8000_0000;
        2, 3, 4: begin
          x = $urandom >> $urandom_range(0, 31);
          if ($urandom_range(0, 1) == 1) x = ~x;
        end
        5:       x = 32'h7FFF_FFFF >> $urandom_range(0, 3);
        default: x = $urandom;
      endcase
      run_op(x);
    end

    repeat (4) @(negedge clk);
    chk("final_idle", bus.busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
